// File: rtl/morph_pkg.sv
// Shared definitions for the 5x5 morphology datapath (window generator,
// dilate and erode cores).
package morph_pkg;

    localparam int PIX_W           = 8;
    localparam int WIN             = 5;
    localparam int DEF_IMG_WIDTH   = 64;
    localparam int DEF_IMG_HEIGHT  = 64;

    typedef logic [PIX_W-1:0] pix_t;

    // Larger of two pixels; the building block of the dilate max tree.
    function automatic pix_t pix_max(input pix_t a, input pix_t b);
        pix_t m;
        if (a > b) begin
            m = a;
        end else begin
            m = b;
        end
        return m;
    endfunction

endpackage

// File: rtl/morph_line_buffer.sv
// Single-row pixel delay: combinational read of the old contents at addr,
// synchronous write of din at the same addr. Storage is never reset; the
// window generator masks stale contents with its row/column gates.
module morph_line_buffer #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         din,
    output logic [PIX_W-1:0]         dout
);

    logic [PIX_W-1:0] mem_r [DEPTH];

    assign dout = mem_r[addr];

    // Write the incoming pixel after its predecessor has been read out.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_r[addr] <= din;
        end
    end

endmodule

// File: rtl/morph_window_5x5.sv
// Streaming 5x5 neighbourhood generator. Four cascaded line buffers feed a
// 5x5 shift window; every accepted pixel that completes an interior window
// loads the 25 registered outputs w0..w24 (row-major, centre at w12).
module morph_window_5x5
    import morph_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    output logic             out_last,
    output logic [PIX_W-1:0] w0,
    output logic [PIX_W-1:0] w1,
    output logic [PIX_W-1:0] w2,
    output logic [PIX_W-1:0] w3,
    output logic [PIX_W-1:0] w4,
    output logic [PIX_W-1:0] w5,
    output logic [PIX_W-1:0] w6,
    output logic [PIX_W-1:0] w7,
    output logic [PIX_W-1:0] w8,
    output logic [PIX_W-1:0] w9,
    output logic [PIX_W-1:0] w10,
    output logic [PIX_W-1:0] w11,
    output logic [PIX_W-1:0] w12,
    output logic [PIX_W-1:0] w13,
    output logic [PIX_W-1:0] w14,
    output logic [PIX_W-1:0] w15,
    output logic [PIX_W-1:0] w16,
    output logic [PIX_W-1:0] w17,
    output logic [PIX_W-1:0] w18,
    output logic [PIX_W-1:0] w19,
    output logic [PIX_W-1:0] w20,
    output logic [PIX_W-1:0] w21,
    output logic [PIX_W-1:0] w22,
    output logic [PIX_W-1:0] w23,
    output logic [PIX_W-1:0] w24
);

    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(IMG_HEIGHT);
    localparam int NLB    = WIN - 1;
    localparam int NWIN   = WIN * WIN;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;
    logic [COL_W-1:0] nxt_col_s;
    logic [ROW_W-1:0] nxt_row_s;
    logic             win_fire_s;
    logic             frame_end_s;

    pix_t lb_dout_s  [NLB];
    pix_t col_in_s   [WIN];
    pix_t win_r      [WIN][WIN];
    pix_t win_next_s [WIN][WIN];
    pix_t out_win_r  [NWIN];
    logic out_valid_r;
    logic out_last_r;

    // Position of the pixel on in_pixel (sof forces the origin) and its successor.
    always_comb begin
        cur_col_s = col_r;
        cur_row_s = row_r;
        nxt_col_s = col_r;
        nxt_row_s = row_r;
        if (in_sof) begin
            cur_col_s = {COL_W{1'b0}};
            cur_row_s = {ROW_W{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end
        if (cur_col_s == COL_LAST) begin
            nxt_col_s = {COL_W{1'b0}};
            if (cur_row_s == ROW_LAST) begin
                nxt_row_s = {ROW_W{1'b0}};
            end else begin
                nxt_row_s = cur_row_s + ROW_W'(1);
            end
        end else begin
            nxt_col_s = cur_col_s + COL_W'(1);
            nxt_row_s = cur_row_s;
        end
    end

    // A window is complete only with four full rows above and four columns to the left.
    always_comb begin
        win_fire_s  = in_valid && (cur_row_s >= ROW_MIN) && (cur_col_s >= COL_MIN);
        frame_end_s = win_fire_s && (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    end

    // Raster position counters, advanced once per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (in_valid) begin
            col_r <= nxt_col_s;
            row_r <= nxt_row_s;
        end
    end

    genvar k;
    generate
        for (k = 0; k < NLB; k++) begin : g_lb
            if (k == 0) begin : g_first
                morph_line_buffer #(
                    .DEPTH (IMG_WIDTH),
                    .PIX_W (PIX_W)
                ) u_lb (
                    .clk  (clk),
                    .en   (in_valid),
                    .addr (cur_col_s),
                    .din  (in_pixel),
                    .dout (lb_dout_s[k])
                );
            end else begin : g_next
                morph_line_buffer #(
                    .DEPTH (IMG_WIDTH),
                    .PIX_W (PIX_W)
                ) u_lb (
                    .clk  (clk),
                    .en   (in_valid),
                    .addr (cur_col_s),
                    .din  (lb_dout_s[k-1]),
                    .dout (lb_dout_s[k])
                );
            end
        end
    endgenerate

    // New right-hand column: oldest row (lb3) on top, live pixel at the bottom.
    always_comb begin
        col_in_s[WIN-1] = in_pixel;
        for (int i = 0; i < NLB; i++) begin
            col_in_s[WIN-2-i] = lb_dout_s[i];
        end
    end

    // Window contents after shifting every row one column left.
    always_comb begin
        for (int i = 0; i < WIN; i++) begin
            for (int j = 0; j < WIN - 1; j++) begin
                win_next_s[i][j] = win_r[i][j+1];
            end
            win_next_s[i][WIN-1] = col_in_s[i];
        end
    end

    // Internal shift window, updated on every accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) begin
                for (int j = 0; j < WIN; j++) begin
                    win_r[i][j] <= {PIX_W{1'b0}};
                end
            end
        end else if (in_valid) begin
            win_r <= win_next_s;
        end
    end

    // Output window registers: loaded only for complete interior windows, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NWIN; n++) begin
                out_win_r[n] <= {PIX_W{1'b0}};
            end
        end else if (win_fire_s) begin
            for (int i = 0; i < WIN; i++) begin
                for (int j = 0; j < WIN; j++) begin
                    out_win_r[WIN*i+j] <= win_next_s[i][j];
                end
            end
        end
    end

    // One-cycle valid / end-of-frame strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            out_valid_r <= win_fire_s;
            out_last_r  <= frame_end_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;

    assign w0  = out_win_r[0];
    assign w1  = out_win_r[1];
    assign w2  = out_win_r[2];
    assign w3  = out_win_r[3];
    assign w4  = out_win_r[4];
    assign w5  = out_win_r[5];
    assign w6  = out_win_r[6];
    assign w7  = out_win_r[7];
    assign w8  = out_win_r[8];
    assign w9  = out_win_r[9];
    assign w10 = out_win_r[10];
    assign w11 = out_win_r[11];
    assign w12 = out_win_r[12];
    assign w13 = out_win_r[13];
    assign w14 = out_win_r[14];
    assign w15 = out_win_r[15];
    assign w16 = out_win_r[16];
    assign w17 = out_win_r[17];
    assign w18 = out_win_r[18];
    assign w19 = out_win_r[19];
    assign w20 = out_win_r[20];
    assign w21 = out_win_r[21];
    assign w22 = out_win_r[22];
    assign w23 = out_win_r[23];
    assign w24 = out_win_r[24];

endmodule

// File: tb/tb_morph_window_5x5.sv
// Self-checking bench for morph_window_5x5 on an 8x8 image. A reference
// model stores the current frame as a 2D image and cuts each expected
// window straight out of it.
module tb_morph_window_5x5;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_sof;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_last;
    logic [7:0] w0, w1, w2, w3, w4, w5, w6, w7, w8, w9, w10, w11, w12;
    logic [7:0] w13, w14, w15, w16, w17, w18, w19, w20, w21, w22, w23, w24;
    logic [199:0] obs_flat;

    int checks   = 0;
    int failures = 0;
    int win_cnt  = 0;
    int hot_cnt  = 0;

    logic [7:0] img [H][W];
    logic [7:0] exp_w [25];
    logic       exp_valid;
    logic       exp_last;
    int         m_row;
    int         m_col;

    always #5 clk = ~clk;

    morph_window_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_last(out_last),
        .w0(w0), .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6),
        .w7(w7), .w8(w8), .w9(w9), .w10(w10), .w11(w11), .w12(w12),
        .w13(w13), .w14(w14), .w15(w15), .w16(w16), .w17(w17), .w18(w18),
        .w19(w19), .w20(w20), .w21(w21), .w22(w22), .w23(w23), .w24(w24)
    );

    assign obs_flat = {w24, w23, w22, w21, w20, w19, w18, w17, w16, w15, w14, w13,
                       w12, w11, w10, w9, w8, w7, w6, w5, w4, w3, w2, w1, w0};

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 25; n++) exp_w[n] = 8'd0;
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_accept(input logic [7:0] pix, input logic sof);
        int r;
        int c;
        if (sof) begin
            r = 0;
            c = 0;
        end else begin
            r = m_row;
            c = m_col;
        end
        img[r][c] = pix;
        exp_valid = (r >= 4) && (c >= 4);
        exp_last  = exp_valid && (r == H - 1) && (c == W - 1);
        if (exp_valid) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    exp_w[5*i+j] = img[r-4+i][c-4+j];
        end
        c++;
        if (c == W) begin
            c = 0;
            r++;
            if (r == H) r = 0;
        end
        m_row = r;
        m_col = c;
    endtask

    task automatic check_outputs(input string tag);
        logic [199:0] exp_flat;
        logic [7:0]   mx;
        for (int n = 0; n < 25; n++) exp_flat[8*n +: 8] = exp_w[n];
        chk({tag, "_valid"}, 200'(out_valid), 200'(exp_valid));
        chk({tag, "_last"},  200'(out_last),  200'(exp_last));
        chk({tag, "_window"}, obs_flat, exp_flat);
        if (out_valid) begin
            win_cnt++;
            mx = 8'd0;
            for (int n = 0; n < 25; n++)
                if (obs_flat[8*n +: 8] > mx) mx = obs_flat[8*n +: 8];
            if (mx == 8'd255) hot_cnt++;
        end
    endtask

    task automatic send(input logic [7:0] pix, input logic sof);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        @(posedge clk);
        model_accept(pix, sof);
        #1;
        check_outputs("px");
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'($urandom);
        @(posedge clk);
        exp_valid = 1'b0;
        exp_last  = 1'b0;
        #1;
        check_outputs("idle");
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        check_outputs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode 0: ramp 8*row+col+base; mode 1: random; mode 2: single 255 at (5,5)
    task automatic send_frame(input int mode, input int base, input bit gaps,
                              input bit sof0, input bit directed);
        logic [7:0] pix;
        for (int p = 0; p < W * H; p++) begin
            case (mode)
                0:       pix = 8'(p + base);
                1:       pix = 8'($urandom);
                default: pix = (p == 5 * W + 5) ? 8'd255 : 8'd0;
            endcase
            if (gaps) repeat ($urandom_range(0, 3)) idle();
            send(pix, sof0 && (p == 0));
            if (directed && p == 35) chk("no_early_window", 200'(win_cnt), 200'(0));
            if (directed && p == 36) begin
                chk("first_w0",  200'(w0),  200'(base));
                chk("first_w12", 200'(w12), 200'(base + 18));
                chk("first_w24", 200'(w24), 200'(base + 36));
            end
            if (directed && p == 63) begin
                chk("last_flag", 200'(out_last), 200'(1));
                chk("last_w12",  200'(w12), 200'(base + 45));
                chk("last_w24",  200'(w24), 200'(base + 63));
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'd0;
        model_reset();
        #12;
        check_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous ramp frame
        win_cnt = 0;
        send_frame(0, 0, 1'b0, 1'b0, 1'b1);
        chk("count_cont", 200'(win_cnt), 200'(16));

        // Same ramp with random idle gaps
        win_cnt = 0;
        send_frame(0, 0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("count_gaps", 200'(win_cnt), 200'(16));

        // Back-to-back frames, second offset by 100
        win_cnt = 0;
        send_frame(0, 0, 1'b0, 1'b0, 1'b0);
        win_cnt = 0;
        send_frame(0, 100, 1'b0, 1'b0, 1'b1);
        chk("count_frame2", 200'(win_cnt), 200'(16));

        // Partial frame, then sof restarts a full frame
        win_cnt = 0;
        for (int p = 0; p < 20; p++) send(8'(p + 7), 1'b0);
        chk("no_spurious_partial", 200'(win_cnt), 200'(0));
        send_frame(0, 0, 1'b0, 1'b1, 1'b1);
        chk("count_sof", 200'(win_cnt), 200'(16));

        // Reset mid-frame after pixel 40
        for (int p = 0; p <= 40; p++) send(8'(p + 50), 1'b0);
        do_reset();
        win_cnt = 0;
        send_frame(0, 0, 1'b0, 1'b0, 1'b1);
        chk("count_after_reset", 200'(win_cnt), 200'(16));

        // Random pixel frame with gaps
        win_cnt = 0;
        send_frame(1, 0, 1'b1, 1'b0, 1'b0);
        chk("count_random", 200'(win_cnt), 200'(16));

        // Single hot pixel: windows whose max is 255
        win_cnt = 0;
        hot_cnt = 0;
        send_frame(2, 0, 1'b0, 1'b0, 1'b0);
        chk("hot_windows", 200'(hot_cnt), 200'(9));
        chk("count_hot", 200'(win_cnt), 200'(16));

        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
